uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit channel (`tx_byte`/`tx_valid`/`tx_ready`) among `NUM_REQ` byte-stream requesters (loopback echo, status reporter, debug dump, and similar).
- Grants are round-robin and locked per frame, so one requester's multi-byte message is never interleaved with another's.
- Sits between the requesters and the `uart` instance's transmit port.
- Presents a registered valid/ready output stage to the UART.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
// Imported by the arbiter and its round-robin picker.
package uart_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Burst counter width; at least one bit even when bursts are unlimited.
  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 0) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The request vector is rotated so that the pointer lands on bit 0, then the lowest set bit is taken and rotated back.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pri;

  assign rot = NUM_REQ'({req, req} >> ptr);
  assign pri = rot & (-rot);
  assign win = NUM_REQ'(({pri, pri} << ptr) >> NUM_REQ);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit port among NUM_REQ byte streams.
// Round-robin grants that stay locked for a whole frame, with a registered output stage.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [BYTE_WIDTH*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BYTE_WIDTH-1:0]         tx_byte,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = cnt_width(MAX_BURST);

  arb_state_t              state;
  logic [PW-1:0]           ptr;
  logic [CW-1:0]           burst_cnt;
  logic [NUM_REQ-1:0]      win;
  logic [PW-1:0]           gidx;
  logic [BYTE_WIDTH-1:0]   sel_byte;
  logic                    sel_last;
  logic                    slot_free;
  logic                    accept;
  logic                    burst_hit;
  logic                    release_now;
  logic [PW-1:0]           nxt_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .win (win)
  );

  // Mux the owner's byte, last flag and index out of the packed inputs.
  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    gidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_byte = req_byte[BYTE_WIDTH*i +: BYTE_WIDTH];
        sel_last = req_last[i];
        gidx     = PW'(i);
      end
    end
  end

  assign slot_free = !tx_valid || tx_ready;
  assign req_ready = (state == ARB_LOCK && slot_free)
                     ? grant : '0;
  assign accept    = (state == ARB_LOCK)
                     && |(req_valid & req_ready);
  assign burst_hit = (MAX_BURST != 0)
                     && (int'(burst_cnt) + 1 == MAX_BURST);
  assign release_now = accept && (sel_last || burst_hit);
  assign nxt_ptr   = (int'(gidx) == NUM_REQ - 1)
                     ? '0 : gidx + PW'(1);
  assign busy      = (state == ARB_LOCK) || tx_valid;

  // Arbitration FSM, grant lock, burst counting and output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
    end else begin
      if (tx_valid && tx_ready && !accept) begin
        tx_valid <= 1'b0;
      end
      unique case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            grant     <= win;
            burst_cnt <= '0;
            state     <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (accept) begin
            tx_byte  <= sel_byte;
            tx_valid <= 1'b1;
            if (burst_cnt != '1) begin
              burst_cnt <= burst_cnt + CW'(1);
            end
            if (release_now) begin
              state <= ARB_IDLE;
              grant <= '0;
              ptr   <= nxt_ptr;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter.
// A queue-based frame model predicts handshakes and outputs every cycle.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .MAX_BURST (MAXB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_byte  (req_byte),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Pending bytes per requester: {last, byte}.
  logic [8:0] src_q [N][$];

  // Model: owner index while a frame is locked, next search start, bytes in this grant, output slot.
  bit         m_lock;
  int         m_own;
  int         m_ptr;
  int         m_cnt;
  bit         m_txv;
  logic [7:0] m_txb;

  logic [N-1:0] en_mask;
  int           vpct;
  int           rdy_pct;

  task automatic model_reset();
    m_lock = 0;
    m_own  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_txv  = 0;
    m_txb  = 8'h00;
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    src_q[r].push_back({l, b});
  endtask

  task automatic push_rand_frame(input int r);
    int len;
    len = int'($urandom_range(1, 6));
    for (int k = 0; k < len; k++) begin
      push(r, 8'($urandom), k == len - 1);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] g;
    g = '0;
    if (m_lock) g[m_own] = 1'b1;
    check("grant", 32'(grant), 32'(g));
    check("tx_valid", 32'(tx_valid), 32'(m_txv));
    check("tx_byte", 32'(tx_byte), 32'(m_txb));
    check("busy", 32'(busy), 32'(m_lock || m_txv));
  endtask

  // One clock: drive, check ready, advance model, check outputs.
  task automatic cycle();
    logic [N-1:0]   rv;
    logic [N-1:0]   rl;
    logic [N-1:0]   exp_rdy;
    logic [8*N-1:0] rb;
    logic [8:0]     it;
    bit             acc;
    bit             drn;
    bit             found;
    rv = '0;
    rl = '0;
    rb = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && en_mask[i]
          && int'($urandom_range(0, 99)) < vpct) begin
        rv[i]       = 1'b1;
        rb[8*i +: 8] = src_q[i][0][7:0];
        rl[i]       = src_q[i][0][8];
      end
    end
    req_valid = rv;
    req_byte  = rb;
    req_last  = rl;
    tx_ready  = int'($urandom_range(0, 99)) < rdy_pct;
    #1;
    exp_rdy = '0;
    if (m_lock && (!m_txv || tx_ready)) exp_rdy[m_own] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clock);
    acc = m_lock && rv[m_own] && exp_rdy[m_own];
    drn = m_txv && tx_ready;
    if (!m_lock) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && rv[(m_ptr + k) % N]) begin
          found  = 1;
          m_own  = (m_ptr + k) % N;
          m_lock = 1;
          m_cnt  = 0;
        end
      end
    end else if (acc) begin
      it    = src_q[m_own].pop_front();
      m_txb = it[7:0];
      m_txv = 1;
      m_cnt++;
      if (it[8] || (MAXB != 0 && m_cnt == MAXB)) begin
        m_lock = 0;
        m_ptr  = (m_own + 1) % N;
      end
    end
    if (drn && !acc) m_txv = 0;
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic bit all_idle();
    bit e;
    e = !m_lock && !m_txv;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) e = 0;
    end
    return e;
  endfunction

  initial begin
    int guard;
    reset_n   = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    en_mask   = '1;
    vpct      = 100;
    rdy_pct   = 100;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;

    // Single requester, three-byte frame.
    push(1, 8'h41, 0);
    push(1, 8'h42, 0);
    push(1, 8'h43, 1);
    en_mask = 4'b0010;
    run(8);

    // Pointer now past requester 1: 3, then 0, then 1.
    push(0, 8'h01, 1);
    push(1, 8'h11, 1);
    push(3, 8'h31, 1);
    en_mask = '1;
    run(12);

    // Two frames competing; no interleave.
    push(0, 8'hA0, 0);
    push(0, 8'hA1, 1);
    push(2, 8'hC0, 1);
    en_mask = 4'b0101;
    run(10);

    // Backpressure holds the first byte stable.
    push(2, 8'h55, 0);
    push(2, 8'h56, 1);
    en_mask = 4'b0100;
    rdy_pct = 0;
    run(12);
    rdy_pct = 100;
    run(5);

    // Burst limit forces release to the waiting requester.
    for (int k = 0; k < 6; k++) push(3, 8'h30 + 8'(k), 0);
    push(3, 8'h3F, 1);
    push(1, 8'h10, 0);
    push(1, 8'h11, 1);
    en_mask = '1;
    run(24);

    // Owner stalls mid-frame while another requests.
    for (int k = 0; k < 5; k++) push(2, 8'h20 + 8'(k), k == 4);
    en_mask = 4'b0100;
    run(3);
    push(0, 8'h0A, 1);
    en_mask = 4'b0001;
    run(5);
    en_mask = '1;
    run(12);

    // Asynchronous reset in the middle of a stalled frame.
    for (int k = 0; k < 5; k++) push(1, 8'h70 + 8'(k), k == 4);
    en_mask = 4'b0010;
    rdy_pct = 0;
    run(3);
    check("pre_reset_txv", 32'(tx_valid), 32'(m_txv));
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_req_ready", 32'(req_ready), 32'h0);
    check("arst_tx_byte", 32'(tx_byte), 32'h0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    model_reset();
    req_valid = '0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    push(3, 8'hD3, 1);
    push(0, 8'hD0, 1);
    en_mask = '1;
    rdy_pct = 100;
    run(10);

    // Randomized traffic.
    vpct    = 75;
    rdy_pct = 65;
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0 && src_q[i].size() < 20) begin
          push_rand_frame(i);
        end
      end
      cycle();
    end

    // Drain everything that is still queued.
    vpct    = 100;
    rdy_pct = 100;
    guard   = 0;
    while (!all_idle() && guard < 500) begin
      cycle();
      guard++;
    end
    check("drain_done", 32'(all_idle()), 32'h1);
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
